// File: rtl/avalon_mm_regs_slave.sv
// avalon_mm_regs_slave
//   Avalon-MM responder behind the UART bridge master. Three read/write config
//   registers, a pop-on-read outbound FIFO filled by the core, and a STATUS word
//   with sticky, write-1-to-clear error flags.
//
//   Map: 0x00 REG0 | 0x04 REG1 | 0x08 REG2 | 0x0C TXDATA (RO, pops) | 0x10 STATUS (W1C)
//   STATUS: [7:0] count, [8] empty, [9] full, [16] underflow, [17] overflow,
//           [18] decode error, [19] read+write conflict.
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   ADDRESS, WRITEDATA   Avalon request address / write data
//   READ, WRITE          Avalon request strobes
//   BEGINTRANSFER, LOCK  accepted but have no effect
//   READDATA             registered read data, valid in the ACK cycle
//   WAITREQUEST          stall to master
//   push_data/valid      core side FIFO write
//   push_ready           FIFO can take a word this cycle
//   reg0_q..reg2_q       config register contents
//   reg_wr_pulse         one-hot pulse, the cycle after a REG0..2 write commits
module avalon_mm_regs_slave #(
    parameter int WAIT_STATES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        WAITREQUEST,
    input  logic        BEGINTRANSFER,
    input  logic        READ,
    input  logic        WRITE,
    input  logic        LOCK,
    input  logic [31:0] push_data,
    input  logic        push_valid,
    output logic        push_ready,
    output logic [31:0] reg0_q,
    output logic [31:0] reg1_q,
    output logic [31:0] reg2_q,
    output logic [2:0]  reg_wr_pulse
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [2:0] IDX_TXDATA = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;

    // Request captured on the IDLE exit edge
    logic [2:0]  req_idx_reg;
    logic        req_ok_reg, req_rd_reg, req_wr_reg, req_conf_reg;
    logic [31:0] req_wdata_reg;
    logic        ack_empty_reg;   // FIFO emptiness seen when READDATA was loaded

    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [3:0]       sticky_reg, sticky_next;
    logic [2:0]       pulse_reg;
    logic [31:0]      readdata_reg;

    logic        unused_ok;
    assign unused_ok = BEGINTRANSFER ^ LOCK;

    // ---------------- live request decode ----------------
    logic [2:0] live_idx;
    logic       live_ok, req_any;
    assign live_idx = ADDRESS[4:2];
    assign live_ok  = (ADDRESS[31:5] == '0) && (ADDRESS[1:0] == 2'b00) && (live_idx <= IDX_STATUS);
    assign req_any  = READ | WRITE;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            S_IDLE: if (req_any) begin
                if (WAIT_STATES == 0) begin
                    state_next = S_ACK;
                end else begin
                    state_next    = S_WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            S_WAIT: if (wait_cnt_reg == 4'd0) state_next = S_ACK;
                    else wait_cnt_next = wait_cnt_reg - 4'd1;
            S_ACK:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign WAITREQUEST = req_any && (state_reg != S_ACK);

    logic capture, enter_ack, in_ack;
    assign capture   = (state_reg == S_IDLE) && req_any;
    assign enter_ack = (state_next == S_ACK);
    assign in_ack    = (state_reg == S_ACK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_idx_reg   <= '0;
            req_ok_reg    <= 1'b0;
            req_rd_reg    <= 1'b0;
            req_wr_reg    <= 1'b0;
            req_conf_reg  <= 1'b0;
            req_wdata_reg <= '0;
        end else if (capture) begin
            req_idx_reg   <= live_idx;
            req_ok_reg    <= live_ok;
            req_rd_reg    <= READ;            // read wins when both strobes are high
            req_wr_reg    <= WRITE & ~READ;
            req_conf_reg  <= READ & WRITE;
            req_wdata_reg <= WRITEDATA;
        end
    end

    // With no wait states ACK is entered on the capture edge itself, so the
    // read mux must look at the live request rather than the captured copy.
    logic [2:0] sel_idx;
    logic       sel_ok, sel_rd;
    assign sel_idx = (state_reg == S_IDLE) ? live_idx : req_idx_reg;
    assign sel_ok  = (state_reg == S_IDLE) ? live_ok  : req_ok_reg;
    assign sel_rd  = (state_reg == S_IDLE) ? READ     : req_rd_reg;

    // ---------------- FIFO ----------------
    logic        fifo_full, fifo_empty, pop, push;
    logic [31:0] fifo_head, status_word, rd_value;
    logic [7:0]  count8;

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    assign count8     = 8'(count_reg);

    // ACK-cycle effects, all derived from the captured request
    logic ack_txrd, ack_write_ok, underflow_set, overflow_set, decerr_set, conflict_set, status_wr;
    assign ack_txrd      = in_ack && req_rd_reg && req_ok_reg && (req_idx_reg == IDX_TXDATA);
    assign pop           = ack_txrd && !ack_empty_reg;
    assign underflow_set = ack_txrd && ack_empty_reg;
    assign ack_write_ok  = in_ack && req_wr_reg && req_ok_reg;
    assign status_wr     = ack_write_ok && (req_idx_reg == IDX_STATUS);
    assign decerr_set    = in_ack && (!req_ok_reg || (req_wr_reg && req_idx_reg == IDX_TXDATA));
    assign conflict_set  = in_ack && req_conf_reg;

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign push_ready   = !fifo_full || pop;
    assign push         = push_valid && push_ready;
    assign overflow_set = push_valid && !push_ready;

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ---------------- STATUS ----------------
    assign status_word = {12'd0, sticky_reg, 6'd0, fifo_full, fifo_empty, count8};

    // New events win over a simultaneous clear
    always_comb begin
        sticky_next = sticky_reg;
        if (status_wr) sticky_next = sticky_next & ~req_wdata_reg[19:16];
        sticky_next = sticky_next | {conflict_set, decerr_set, overflow_set, underflow_set};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sticky_reg <= '0;
        else     sticky_reg <= sticky_next;
    end

    // ---------------- config registers ----------------
    logic [2:0] wr_hit;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
            logic [31:0] q_reg;
            assign wr_hit[gi] = ack_write_ok && (req_idx_reg == 3'(gi));
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)             q_reg <= '0;
                else if (wr_hit[gi]) q_reg <= req_wdata_reg;
            end
        end
    endgenerate

    assign reg0_q = g_cfg[0].q_reg;
    assign reg1_q = g_cfg[1].q_reg;
    assign reg2_q = g_cfg[2].q_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pulse_reg <= '0;
        else     pulse_reg <= wr_hit;
    end
    assign reg_wr_pulse = pulse_reg;

    // ---------------- read data ----------------
    always_comb begin
        rd_value = '0;
        if (sel_rd && sel_ok) begin
            case (sel_idx)
                3'd0:       rd_value = reg0_q;
                3'd1:       rd_value = reg1_q;
                3'd2:       rd_value = reg2_q;
                IDX_TXDATA: rd_value = fifo_empty ? 32'd0 : fifo_head;
                IDX_STATUS: rd_value = status_word;
                default:    rd_value = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            readdata_reg  <= '0;
            ack_empty_reg <= 1'b1;
        end else if (enter_ack) begin
            readdata_reg  <= rd_value;
            ack_empty_reg <= fifo_empty;
        end
    end
    assign READDATA = readdata_reg;

endmodule

// File: tb/tb_avalon_mm_regs_slave.sv
module tb_avalon_mm_regs_slave;
    localparam int WS    = 2;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] ADDRESS, WRITEDATA, READDATA;
    logic        WAITREQUEST, BEGINTRANSFER, READ, WRITE, LOCK;
    logic [31:0] push_data;
    logic        push_valid, push_ready;
    logic [31:0] reg0_q, reg1_q, reg2_q;
    logic [2:0]  reg_wr_pulse;

    avalon_mm_regs_slave #(.WAIT_STATES(WS), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READDATA(READDATA), .WAITREQUEST(WAITREQUEST), .BEGINTRANSFER(BEGINTRANSFER),
        .READ(READ), .WRITE(WRITE), .LOCK(LOCK), .push_data(push_data),
        .push_valid(push_valid), .push_ready(push_ready), .reg0_q(reg0_q),
        .reg1_q(reg1_q), .reg2_q(reg2_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: transaction level view of the register file
    logic [31:0] m_regs [3];
    logic [31:0] m_fifo [$];
    logic [3:0]  m_sticky;   // {conflict, decerr, overflow, underflow}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = '0;
        m_fifo.delete();
        m_sticky = '0;
    endtask

    function automatic logic [31:0] m_status();
        int n;
        n = m_fifo.size();
        return {12'd0, m_sticky, 6'd0, (n == DEPTH) ? 1'b1 : 1'b0, (n == 0) ? 1'b1 : 1'b0, 8'(n)};
    endfunction

    task automatic m_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] exp_rd,
                          output logic [2:0] exp_pulse);
        bit ok;
        int idx;
        idx = int'(addr[4:2]);
        ok  = (addr[31:5] == 0) && (addr[1:0] == 0) && (idx <= 4);
        exp_rd = '0;
        exp_pulse = '0;
        if (rd) begin
            if (!ok) m_sticky[2] = 1'b1;
            else if (idx < 3) exp_rd = m_regs[idx];
            else if (idx == 3) begin
                if (m_fifo.size() == 0) m_sticky[0] = 1'b1;
                else exp_rd = m_fifo.pop_front();
            end else exp_rd = m_status();
        end else if (wr) begin
            if (!ok || idx == 3) m_sticky[2] = 1'b1;
            else if (idx == 4) m_sticky = m_sticky & ~wdata[19:16];
            else begin
                m_regs[idx] = wdata;
                exp_pulse = 3'(1 << idx);
            end
        end
        if (rd && wr) m_sticky[3] = 1'b1;
    endtask

    // Drives one Avalon transfer; optionally pushes a core word during the ACK cycle.
    task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic do_push, input logic [31:0] pword,
                       output logic [31:0] rdata, output int wr_cycles, output logic rdy_seen);
        logic done;
        done = 1'b0;
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata; BEGINTRANSFER = 1'b1;
        wr_cycles = 0; rdata = 'x; rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (WAITREQUEST === 1'b0) begin
                rdata = READDATA;
                done = 1'b1;
                if (do_push) begin
                    push_valid = 1'b1; push_data = pword;
                    #1 rdy_seen = push_ready;
                end
                break;
            end
            wr_cycles++;
            BEGINTRANSFER = 1'b0;
        end
        check("bus_timeout", {31'd0, done}, 32'd1);
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0; BEGINTRANSFER = 1'b0; push_valid = 1'b0;
    endtask

    task automatic do_xfer(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic [2:0]  exp_pulse;
        int          lat;
        logic        rdy;
        m_xfer(rd, wr, addr, wdata, exp_rd, exp_pulse);
        bus(rd, wr, addr, wdata, 1'b0, 32'd0, rdata, lat, rdy);
        $display("xfer %s rd=%0b wr=%0b addr=%08h wdata=%08h rdata=%08h wait=%0d",
                 tag, rd, wr, addr, wdata, rdata, lat);
        if (rd) check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        check({tag, "_pulse"}, {29'd0, reg_wr_pulse}, {29'd0, exp_pulse});
        check({tag, "_reg0"}, reg0_q, m_regs[0]);
        check({tag, "_reg1"}, reg1_q, m_regs[1]);
        check({tag, "_reg2"}, reg2_q, m_regs[2]);
        @(posedge CLK); #1;
        check({tag, "_pulse_off"}, {29'd0, reg_wr_pulse}, 32'd0);
    endtask

    task automatic do_push(input string tag, input logic [31:0] word);
        logic exp_rdy;
        push_valid = 1'b1; push_data = word;
        exp_rdy = (m_fifo.size() < DEPTH);
        $display("push %s data=%08h ready=%0b", tag, word, push_ready);
        check({tag, "_ready"}, {31'd0, push_ready}, {31'd0, exp_rdy});
        if (exp_rdy) m_fifo.push_back(word);
        else m_sticky[1] = 1'b1;
        @(posedge CLK); #1;
        push_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rdata;
    logic [31:0] bad_addrs [7] = '{32'h14, 32'h18, 32'h1C, 32'h20, 32'h102, 32'h01, 32'h8000_0004};
    logic [31:0] any_addrs [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};

    initial begin
        logic [31:0] exp_rd, w;
        logic [2:0]  exp_pulse;
        int          lat, op;
        logic        rdy;

        RST = 1'b1; ADDRESS = '0; WRITEDATA = '0; BEGINTRANSFER = 1'b0;
        READ = 1'b0; WRITE = 1'b0; LOCK = 1'b0; push_data = '0; push_valid = 1'b0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_readdata", READDATA, 32'd0);
        check("rst_waitreq", {31'd0, WAITREQUEST}, 32'd0);
        check("rst_push_ready", {31'd0, push_ready}, 32'd1);
        check("rst_reg0", reg0_q, 32'd0);
        check("rst_reg1", reg1_q, 32'd0);
        check("rst_reg2", reg2_q, 32'd0);
        check("rst_pulse", {29'd0, reg_wr_pulse}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // 1: register write with wait states
        do_xfer("t1_wr_reg1", 1'b0, 1'b1, 32'h04, 32'h12345678, rdata);
        check("t1_reg1_const", reg1_q, 32'h12345678);

        // 2: FIFO order
        do_push("t2_push_a1", 32'hA1);
        do_push("t2_push_a2", 32'hA2);
        do_xfer("t2_pop1", 1'b1, 1'b0, 32'h0C, 32'd0, rdata);
        check("t2_pop1_const", rdata, 32'hA1);
        do_xfer("t2_pop2", 1'b1, 1'b0, 32'h0C, 32'd0, rdata);
        check("t2_pop2_const", rdata, 32'hA2);
        do_xfer("t2_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
        check("t2_status_const", rdata, 32'h0000_0100);

        // 3: underflow and W1C
        do_xfer("t3_pop_empty", 1'b1, 1'b0, 32'h0C, 32'd0, rdata);
        do_xfer("t3_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
        check("t3_status_const", rdata, 32'h0001_0100);
        do_xfer("t3_w1c", 1'b0, 1'b1, 32'h10, 32'h0001_0000, rdata);
        do_xfer("t3_status2", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
        check("t3_status2_const", rdata, 32'h0000_0100);

        // 4: overflow, then push+pop while full
        for (int i = 0; i < 5; i++) do_push("t4_push", 32'hB0 + 32'(i));
        check("t4_ready_low", {31'd0, push_ready}, 32'd0);
        do_xfer("t4_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
        check("t4_status_const", rdata, 32'h0002_0204);
        m_xfer(1'b1, 1'b0, 32'h0C, 32'd0, exp_rd, exp_pulse);
        m_fifo.push_back(32'hC5);
        bus(1'b1, 1'b0, 32'h0C, 32'd0, 1'b1, 32'hC5, rdata, lat, rdy);
        $display("xfer t4_popush rdata=%08h push_ready=%0b wait=%0d", rdata, rdy, lat);
        check("t4_popush_rdata", rdata, exp_rd);
        check("t4_popush_ready", {31'd0, rdy}, 32'd1);
        do_xfer("t4_status2", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
        check("t4_status2_const", rdata, 32'h0002_0204);
        for (int i = 0; i < 4; i++) do_xfer("t4_drain", 1'b1, 1'b0, 32'h0C, 32'd0, rdata);
        do_xfer("t4_clr", 1'b0, 1'b1, 32'h10, 32'h000F_0000, rdata);

        // 5: decode errors
        do_xfer("t5_rd_14", 1'b1, 1'b0, 32'h14, 32'd0, rdata);
        do_xfer("t5_wr_0c", 1'b0, 1'b1, 32'h0C, 32'hFFFF_FFFF, rdata);
        do_xfer("t5_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
        check("t5_status_const", rdata, 32'h0004_0100);
        check("t5_reg1_kept", reg1_q, 32'h12345678);

        // 6: reset in the middle of a write
        do_xfer("t6_wr_reg0", 1'b0, 1'b1, 32'h00, 32'h55AA_55AA, rdata);
        WRITE = 1'b1; ADDRESS = 32'h00; WRITEDATA = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        check("t6_in_wait", {31'd0, WAITREQUEST}, 32'd1);
        RST = 1'b1;
        #1;
        m_reset();
        check("t6_reg0_cleared", reg0_q, 32'd0);
        check("t6_no_pulse", {29'd0, reg_wr_pulse}, 32'd0);
        WRITE = 1'b0; READ = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        do_xfer("t6_read_after", 1'b1, 1'b0, 32'h00, 32'd0, rdata);
        do_xfer("t6_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);

        // Randomised mix against the model
        for (int t = 0; t < 200; t++) begin
            op = $urandom_range(0, 9);
            w  = $urandom();
            case (op)
                0: do_xfer("r_wr_reg", 1'b0, 1'b1, 32'($urandom_range(0, 2)) << 2, w, rdata);
                1: do_xfer("r_rd_reg", 1'b1, 1'b0, 32'($urandom_range(0, 2)) << 2, 32'd0, rdata);
                2, 3: do_push("r_push", w);
                4: do_xfer("r_pop", 1'b1, 1'b0, 32'h0C, 32'd0, rdata);
                5: do_xfer("r_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);
                6: do_xfer("r_w1c", 1'b0, 1'b1, 32'h10, w, rdata);
                7: begin
                    rdy = 1'($urandom_range(0, 1));
                    do_xfer("r_bad", rdy, !rdy, bad_addrs[$urandom_range(0, 6)], w, rdata);
                end
                8: do_xfer("r_conflict", 1'b1, 1'b1, any_addrs[$urandom_range(0, 5)], w, rdata);
                default: do_xfer("r_wr_tx", 1'b0, 1'b1, 32'h0C, w, rdata);
            endcase
        end
        do_xfer("final_status", 1'b1, 1'b0, 32'h10, 32'd0, rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
